// File: rtl/sd_dat0_block_rx.sv
// rtl/sd_dat0_block_rx.sv - single-line SD DAT0 block receiver: start bit, 512 bytes MSB-first, CRC16, end bit.
// Optional build macro: SD_RX_CRC_CHECK_EN (computes CRC16 and flags a received-CRC mismatch).
module sd_dat0_block_rx #(
    parameter int unsigned TIMEOUT_EDGES = 1000000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       sdclk,
    input  logic       sddat0,
    input  logic       start,
    input  logic       abort,
    output logic       busy,
    output logic       outen,
    output logic [8:0] outaddr,
    output logic [7:0] outbyte,
    output logic       done,
    output logic       timeout,
    output logic       crc_err
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_WAIT_START = 3'd1;
    localparam logic [2:0] S_DATA       = 3'd2;
    localparam logic [2:0] S_CRC        = 3'd3;
    localparam logic [2:0] S_ENDBIT     = 3'd4;
    localparam logic [2:0] S_FIN        = 3'd5;

    logic [2:0]  state;
    logic        sdclk_l;
    logic [31:0] edge_cnt;
    logic [11:0] bit_cnt;
    logic [6:0]  shift_q;
    logic        sd_edge;
    logic        crc_bad;

    // sdclk is a slow copy in this domain; a rising edge is one clk wide
    assign sd_edge = ~sdclk_l & sdclk;
    assign busy    = (state != S_IDLE);

`ifdef SD_RX_CRC_CHECK_EN
    logic [15:0] crc_calc;
    logic [15:0] crc_rx;

    function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[15] ^ b;
        return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    assign crc_bad = (crc_rx != crc_calc);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            crc_calc <= 16'h0000;
            crc_rx   <= 16'h0000;
        end else if (!abort) begin
            if (state == S_IDLE && start) begin
                crc_calc <= 16'h0000;
                crc_rx   <= 16'h0000;
            end else if (sd_edge && state == S_DATA) begin
                crc_calc <= crc16_step(crc_calc, sddat0);
            end else if (sd_edge && state == S_CRC) begin
                crc_rx <= {crc_rx[14:0], sddat0};
            end
        end
    end
`else
    assign crc_bad = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= S_IDLE;
            sdclk_l  <= 1'b0;
            edge_cnt <= 32'd0;
            bit_cnt  <= 12'd0;
            shift_q  <= 7'd0;
            outen    <= 1'b0;
            outaddr  <= 9'd0;
            outbyte  <= 8'd0;
            done     <= 1'b0;
            timeout  <= 1'b0;
            crc_err  <= 1'b0;
        end else begin
            sdclk_l <= sdclk;
            outen   <= 1'b0;
            done    <= 1'b0;
            if (abort) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            timeout  <= 1'b0;
                            crc_err  <= 1'b0;
                            bit_cnt  <= 12'd0;
                            edge_cnt <= 32'd0;
                            state    <= S_WAIT_START;
                        end
                    end
                    S_WAIT_START: begin
                        if (sd_edge) begin
                            if (!sddat0) begin
                                state <= S_DATA;
                            end else begin
                                edge_cnt <= edge_cnt + 32'd1;
                                if (edge_cnt + 32'd1 == TIMEOUT_EDGES) begin
                                    timeout <= 1'b1;
                                    done    <= 1'b1;
                                    state   <= S_FIN;
                                end
                            end
                        end
                    end
                    S_DATA: begin
                        if (sd_edge) begin
                            shift_q <= {shift_q[5:0], sddat0};
                            bit_cnt <= bit_cnt + 12'd1;
                            if (bit_cnt[2:0] == 3'd7) begin
                                outen   <= 1'b1;
                                outbyte <= {shift_q, sddat0};
                                outaddr <= bit_cnt[11:3];
                            end
                            // bit_cnt wraps to 0 here and then counts the CRC bits
                            if (bit_cnt == 12'd4095) begin
                                state <= S_CRC;
                            end
                        end
                    end
                    S_CRC: begin
                        if (sd_edge) begin
                            bit_cnt <= bit_cnt + 12'd1;
                            if (bit_cnt[3:0] == 4'd15) begin
                                state <= S_ENDBIT;
                            end
                        end
                    end
                    S_ENDBIT: begin
                        if (sd_edge) begin
                            if (!sddat0 || crc_bad) begin
                                crc_err <= 1'b1;
                            end
                            done  <= 1'b1;
                            state <= S_FIN;
                        end
                    end
                    S_FIN: begin
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/sd_dat0_block_rx.md
# sd_dat0_block_rx

Single-line SD-bus data receiver: after the command engine has issued CMD17 (READ_SINGLE_BLOCK), it watches SDDAT0 for the start bit and deserialises one 512-byte sector MSB-first. It streams the sector out as addressed bytes and checks the trailing CRC16 and end bit. It sits beside the command host and is the read-side counterpart of the single-block DAT0 writer, sharing the same `sdclk` and card-address flow.

## Interface
- `TIMEOUT_EDGES`, 1000000: `sdclk` rising edges allowed in WAIT_START before timeout (80 ms at 12.5 MHz).
- `clk`  in  1  system clock; `sdclk` is oversampled in this domain.
- `rstn`  in  1  reset, asynchronous, active-low.
- `sdclk`  in  1  SD clock copy generated in the `clk` domain by the command host.
- `sddat0`  in  1  card DAT0 line, input only.
- `start`  in  1  one-cycle pulse; arms reception. Ignored while `busy`=1.
- `abort`  in  1  level; forces return to IDLE with no `done`.
- `busy`  out  1  1 in every state except IDLE.
- `outen`  out  1  one-cycle byte strobe.
- `outaddr`  out  9  byte index 0..511, valid with `outen`.
- `outbyte`  out  8  received byte, valid with `outen`.
- `done`  out  1  one-cycle pulse at the end of a block or a timeout.
- `timeout`  out  1  status; held from `done` until the next accepted `start`.
- `crc_err`  out  1  status; CRC mismatch or end bit = 0; held like `timeout`.

## Operation
- Edge detect: `sdclk_l` <= `sdclk` every `clk`. A rising edge is `~sdclk_l & sdclk`. `sddat0` is sampled only in that `clk` cycle.
- States: IDLE, WAIT_START, DATA, CRC, ENDBIT, FIN.
- IDLE: on `start`, clear `timeout`, `crc_err`, bit counter, edge counter and CRC register, then go to WAIT_START.
- WAIT_START: on each edge, `sddat0`=0 goes to DATA. Otherwise increment the edge counter (32 bit). When the count reaches `TIMEOUT_EDGES`, set `timeout`=1 and go to FIN.
- DATA: on each edge, shift `sddat0` into an 8-bit shift register LSB-in, so the byte is assembled MSB-first. The bit counter (12 bit) runs 0..4095. When bit[2:0]=7, the next `clk` drives `outen`=1, `outbyte`=assembled byte and `outaddr`=counter[11:3]. After bit 4095, go to CRC.
- CRC: capture 16 bits MSB-first over 16 edges, then go to ENDBIT.
- ENDBIT: sample one edge. A value of 0 sets `crc_err`. Compare the received CRC with the computed CRC; a mismatch sets `crc_err`. Go to FIN.
- FIN: pulse `done` for one `clk`, then go to IDLE.
- CRC16: polynomial x^16+x^12+x^5+1 (0x1021), init 0x0000, computed over the 4096 data bits in wire order, one bit per edge.
- `abort`=1 has priority over all transitions. The next state is IDLE. No `outen` or `done` is issued after the abort cycle, and status flags keep their values.
- `start` and `abort` in the same cycle: `abort` wins and the block stays in IDLE.
- Reset values: `busy` 0, `outen` 0, `outaddr` 0, `outbyte` 0, `done` 0, `timeout` 0, `crc_err` 0; state IDLE. Reset mid-block discards the partial sector immediately.
- `outaddr` and `outbyte` hold their last value when `outen`=0, except after reset.

## Timing
- `start` to `busy`=1: 1 `clk`.
- Byte strobe: `outen` asserts 1 `clk` after the `clk` that sampled the byte's 8th bit. With `clk`/`sdclk` ≥ 4, strobes are spaced ≥ 8 `sdclk` periods apart.
- `done`: asserts 1 `clk` after the end-bit sample (normal path) or after the timeout edge. `busy` drops the `clk` after `done`.
- Whole block: start bit + 4096 + 16 + 1 edges after entering WAIT_START, plus 2 `clk`.
- Requirement: each `sdclk` high and low phase lasts ≥ 1 `clk`.

## Configuration
- `SD_RX_CRC_CHECK_EN` defined: the CRC16 register is instantiated, and a mismatch sets `crc_err`.
- `SD_RX_CRC_CHECK_EN` undefined: no CRC logic is built. The 16 CRC bits are still consumed, but `crc_err` is set only by end bit = 0.

## Test plan
- Block of 512 × 0xFF, CRC 0x7FA1, end bit 1 → 512 `outen` pulses with `outbyte`=0xFF and `outaddr` 0..511 in order; `done`=1, `crc_err`=0, `timeout`=0.
- Block `outbyte`[i] = i & 0xFF with correct model CRC → byte/address match for all 512; `crc_err`=0.
- Same block with CRC bit 0 flipped → `crc_err`=1 only with the macro defined, otherwise 0. End bit forced 0 → `crc_err`=1 in both builds.
- `TIMEOUT_EDGES`=100, `sddat0` held 1 → `done` and `timeout`=1 after exactly 100 edges; zero `outen` pulses.
- `abort` after byte 37 → `busy`=0 next `clk`; no further `outen` and no `done`. A following `start` receives a clean block correctly.
- Second `start` mid-block is ignored. `rstn`=0 mid-block → all outputs 0 and state IDLE asynchronously.
